// File: rtl/matrix_bus_initiator.sv
// matrix_bus_initiator
//   Sole master of the shared matrix data bus. For each accepted command it
//   reads operand A (and operand B unless singleOperand) from matrix memory,
//   presents them to the execution datapath, waits for the result with a
//   bounded timeout, and writes the result back to the destination address.
//
// Ports
//   clk, reset                 single clock, synchronous active-high reset
//   startValid / startReady    command handshake (ready only while idle)
//   srcAddrA, srcAddrB,        command fields, latched on acceptance
//   destAddr, singleOperand
//   operandA, operandB         captured operands (B is zero for single-operand)
//   operandValid               one-cycle pulse when operands are stable
//   resultData / resultValid   datapath result, accepted while resultReady
//   resultReady                high while waiting for the result
//   done, timeoutError         completion pulse; timeoutError marks an abort
//   address, nMatrixMemEnable, memory bus: active-low enable, 1 = read
//   ReadnWrite, dataBus        dataBus is driven only during the write cycle

module matrix_bus_initiator #(
  parameter int DATA_WIDTH     = 256,
  parameter int ADDR_WIDTH     = 8,
  parameter int RESULT_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  startValid,
  output logic                  startReady,
  input  logic [ADDR_WIDTH-1:0] srcAddrA,
  input  logic [ADDR_WIDTH-1:0] srcAddrB,
  input  logic [ADDR_WIDTH-1:0] destAddr,
  input  logic                  singleOperand,
  output logic [DATA_WIDTH-1:0] operandA,
  output logic [DATA_WIDTH-1:0] operandB,
  output logic                  operandValid,
  input  logic [DATA_WIDTH-1:0] resultData,
  input  logic                  resultValid,
  output logic                  resultReady,
  output logic                  done,
  output logic                  timeoutError,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  nMatrixMemEnable,
  output logic                  ReadnWrite,
  inout  wire  [DATA_WIDTH-1:0] dataBus
);

  // Wide enough to hold RESULT_TIMEOUT itself.
  localparam int CNT_W = (RESULT_TIMEOUT < 2) ? 1 : $clog2(RESULT_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(RESULT_TIMEOUT);

  typedef enum logic [3:0] {
    IDLE, RDA_REQ, RDA_CAP, RDB_REQ, RDB_CAP, ISSUE, WAIT_RES, WRITE, DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_a_q, src_a_d;
  logic [ADDR_WIDTH-1:0] src_b_q, src_b_d;
  logic [ADDR_WIDTH-1:0] dest_q, dest_d;
  logic                  single_q, single_d;
  logic [DATA_WIDTH-1:0] operand_a_q, operand_a_d;
  logic [DATA_WIDTH-1:0] operand_b_q, operand_b_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  timeout_err_q, timeout_err_d;
  logic                  bus_drive;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      src_a_q       <= '0;
      src_b_q       <= '0;
      dest_q        <= '0;
      single_q      <= 1'b0;
      operand_a_q   <= '0;
      operand_b_q   <= '0;
      result_q      <= '0;
      count_q       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      src_a_q       <= src_a_d;
      src_b_q       <= src_b_d;
      dest_q        <= dest_d;
      single_q      <= single_d;
      operand_a_q   <= operand_a_d;
      operand_b_q   <= operand_b_d;
      result_q      <= result_d;
      count_q       <= count_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d       = state_q;
    src_a_d       = src_a_q;
    src_b_d       = src_b_q;
    dest_d        = dest_q;
    single_d      = single_q;
    operand_a_d   = operand_a_q;
    operand_b_d   = operand_b_q;
    result_d      = result_q;
    count_d       = count_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      IDLE: begin
        if (startValid) begin
          src_a_d       = srcAddrA;
          src_b_d       = srcAddrB;
          dest_d        = destAddr;
          single_d      = singleOperand;
          timeout_err_d = 1'b0;
          state_d       = RDA_REQ;
        end
      end
      RDA_REQ: state_d = RDA_CAP;
      RDA_CAP: begin
        // Memory drives its registered read data during the capture cycle.
        operand_a_d = dataBus;
        if (single_q) begin
          operand_b_d = '0;
          state_d     = ISSUE;
        end else begin
          state_d = RDB_REQ;
        end
      end
      RDB_REQ: state_d = RDB_CAP;
      RDB_CAP: begin
        operand_b_d = dataBus;
        state_d     = ISSUE;
      end
      ISSUE: begin
        count_d = '0;
        state_d = WAIT_RES;
      end
      WAIT_RES: begin
        // A result arriving on the final allowed cycle still wins.
        if (resultValid) begin
          result_d = resultData;
          state_d  = WRITE;
        end else begin
          count_d = count_q + 1'b1;
          if (count_d == TIMEOUT_VAL) begin
            timeout_err_d = 1'b1;
            state_d       = DONE;
          end
        end
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and bus outputs decode directly from the state register.
  always_comb begin
    startReady       = (state_q == IDLE);
    operandValid     = (state_q == ISSUE);
    resultReady      = (state_q == WAIT_RES);
    done             = (state_q == DONE);
    nMatrixMemEnable = 1'b1;
    ReadnWrite       = 1'b1;
    address          = '0;
    bus_drive        = 1'b0;
    case (state_q)
      RDA_REQ, RDA_CAP: begin
        nMatrixMemEnable = 1'b0;
        address          = src_a_q;
      end
      RDB_REQ, RDB_CAP: begin
        nMatrixMemEnable = 1'b0;
        address          = src_b_q;
      end
      WRITE: begin
        nMatrixMemEnable = 1'b0;
        ReadnWrite       = 1'b0;
        address          = dest_q;
        bus_drive        = 1'b1;
      end
      default: ;
    endcase
  end

  assign operandA     = operand_a_q;
  assign operandB     = operand_b_q;
  assign timeoutError = timeout_err_q;
  assign dataBus      = bus_drive ? result_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_matrix_bus_initiator.sv
// Bench for matrix_bus_initiator. dut1 uses the default timeout and sits on a
// registered-output memory model; dut2 uses RESULT_TIMEOUT=4 for the abort
// cases. A weak-looking "keeper" drives zero whenever no legitimate driver
// should own a bus, so any stray DUT drive shows up as a non-zero value.
module tb_matrix_bus_initiator;
  localparam int DW = 256;
  localparam int AW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1;

  int checks = 0;
  int errors = 0;

  // ---------------- dut1 ----------------
  logic          start_valid = 1'b0, start_ready, single = 1'b0;
  logic [AW-1:0] src_a = '0, src_b = '0, dest = '0, addr;
  logic [DW-1:0] op_a, op_b, res_data = '0;
  logic          op_valid, res_valid = 1'b0, res_ready, done, t_err, n_en, rnw;
  tri   [DW-1:0] bus;

  matrix_bus_initiator dut1 (
    .clk(clk), .reset(reset), .startValid(start_valid), .startReady(start_ready),
    .srcAddrA(src_a), .srcAddrB(src_b), .destAddr(dest), .singleOperand(single),
    .operandA(op_a), .operandB(op_b), .operandValid(op_valid),
    .resultData(res_data), .resultValid(res_valid), .resultReady(res_ready),
    .done(done), .timeoutError(t_err), .address(addr),
    .nMatrixMemEnable(n_en), .ReadnWrite(rnw), .dataBus(bus)
  );

  // Memory: registers read data on the first enabled read cycle of a pair
  // and drives it during the second; captures writes on the clock edge.
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] mem_out_q = '0;
  logic          mem_oe_q  = 1'b0;
  always @(posedge clk) begin
    if (!n_en && rnw && !mem_oe_q) begin
      mem_out_q <= mem[addr];
      mem_oe_q  <= 1'b1;
    end else begin
      mem_oe_q <= 1'b0;
    end
    if (!n_en && !rnw) mem[addr] <= bus;
  end
  assign bus = mem_oe_q ? mem_out_q : {DW{1'bz}};
  assign bus = (!mem_oe_q && rnw) ? {DW{1'b0}} : {DW{1'bz}};

  // ---------------- dut2 (short timeout) ----------------
  logic          start_valid2 = 1'b0, start_ready2, op_valid2, res_ready2, done2, t_err2;
  logic          n_en2, rnw2, res_valid2 = 1'b0;
  logic [AW-1:0] addr2;
  logic [DW-1:0] op_a2, op_b2;
  logic [DW-1:0] res_data2 = 256'hBEEF_0123;
  logic [AW-1:0] src_a2 = 8'd0, src_b2 = 8'd1, dest2 = 8'd2;
  tri   [DW-1:0] bus2;
  assign bus2 = rnw2 ? {DW{1'b0}} : {DW{1'bz}};

  matrix_bus_initiator #(.RESULT_TIMEOUT(4)) dut2 (
    .clk(clk), .reset(reset), .startValid(start_valid2), .startReady(start_ready2),
    .srcAddrA(src_a2), .srcAddrB(src_b2), .destAddr(dest2), .singleOperand(1'b0),
    .operandA(op_a2), .operandB(op_b2), .operandValid(op_valid2),
    .resultData(res_data2), .resultValid(res_valid2), .resultReady(res_ready2),
    .done(done2), .timeoutError(t_err2), .address(addr2),
    .nMatrixMemEnable(n_en2), .ReadnWrite(rnw2), .dataBus(bus2)
  );

  // ---------------- bus monitors ----------------
  int bus_viol = 0, bus_viol2 = 0;
  always @(negedge clk) begin
    if (rnw && !mem_oe_q && bus !== {DW{1'b0}}) bus_viol++;
    if (!rnw && n_en) bus_viol++;
    if (rnw2 && bus2 !== {DW{1'b0}}) bus_viol2++;
    if (!rnw2 && n_en2) bus_viol2++;
  end

  // ---------------- helpers ----------------
  typedef struct {
    logic [AW-1:0] a, b, d;
    logic          s;
    int            resp;
    logic [DW-1:0] exp_a, exp_b, exp_w;
    int            exp_valid, exp_wr, exp_done, exp_ra, exp_rb;
  } vec_t;

  typedef struct {
    logic [DW-1:0] op_a, op_b, w_data;
    logic [AW-1:0] w_addr;
    int            valid_cyc, wr_cyc, done_cyc, ready_cnt, write_cnt;
    int            reads_a, reads_b, sr_busy;
    logic          terr, terr_start;
  } obs_t;

  function automatic logic [DW-1:0] pattern(input int i);
    logic [DW-1:0] v;
    for (int k = 0; k < 8; k++)
      v[k*32 +: 32] = 32'hA5A5_0000 + 32'(i) * 32'h0001_0203 + 32'(k);
    return v;
  endfunction

  function automatic vec_t mk(input int a, input int b, input int d, input bit s,
                              input int resp, input int vc, input int wc, input int dc);
    vec_t v;
    v.a = AW'(a); v.b = AW'(b); v.d = AW'(d); v.s = s; v.resp = resp;
    v.exp_a = pattern(a);
    v.exp_b = s ? '0 : pattern(b);
    v.exp_w = v.exp_a + v.exp_b;
    v.exp_valid = vc; v.exp_wr = wc; v.exp_done = dc;
    v.exp_ra = 2; v.exp_rb = s ? 0 : 2;
    return v;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one command on dut1 and watch it until done (bounded). Returns in
  // the cycle after DONE. With hold_start, startValid stays high and the
  // inputs switch to nxt right after acceptance.
  task automatic run_cmd(input vec_t v, input bit hold_start, input vec_t nxt, output obs_t o);
    int cyc;
    o = '{default: 0};
    src_a = v.a; src_b = v.b; dest = v.d; single = v.s; start_valid = 1'b1;
    @(posedge clk); #1;
    if (hold_start) begin
      src_a = nxt.a; src_b = nxt.b; dest = nxt.d; single = nxt.s;
    end else begin
      start_valid = 1'b0;
    end
    cyc = 1;
    while (cyc < 400) begin
      res_valid = 1'b0;
      if (op_valid) begin o.valid_cyc = cyc; o.op_a = op_a; o.op_b = op_b; end
      if (start_ready) o.sr_busy++;
      if (!n_en && rnw && addr == v.a) o.reads_a++;
      if (!n_en && rnw && addr == v.b) o.reads_b++;
      if (!n_en && !rnw) begin
        o.write_cnt++; o.wr_cyc = cyc; o.w_addr = addr; o.w_data = bus;
      end
      if (res_ready) begin
        o.ready_cnt++;
        if (o.ready_cnt == v.resp) begin res_valid = 1'b1; res_data = op_a + op_b; end
      end
      if (done) begin o.done_cyc = cyc; o.terr = t_err; end
      @(posedge clk); #1;
      if (o.done_cyc != 0) break;
      cyc++;
    end
    res_valid = 1'b0;
  endtask

  task automatic check_cmd(input string tag, input vec_t v, input obs_t o);
    check({tag, " opA"}, o.op_a, v.exp_a);
    check({tag, " opB"}, o.op_b, v.exp_b);
    check({tag, " valid_cycle"}, o.valid_cyc, v.exp_valid);
    check({tag, " ready_cycles"}, o.ready_cnt, v.resp);
    check({tag, " write_count"}, o.write_cnt, 1);
    check({tag, " write_addr"}, o.w_addr, v.d);
    check({tag, " write_data"}, o.w_data, v.exp_w);
    check({tag, " write_cycle"}, o.wr_cyc, v.exp_wr);
    check({tag, " done_cycle"}, o.done_cyc, v.exp_done);
    check({tag, " timeout_err"}, o.terr, 0);
    check({tag, " reads_srcA"}, o.reads_a, v.exp_ra);
    check({tag, " reads_srcB"}, o.reads_b, v.exp_rb);
    check({tag, " busy_ready"}, o.sr_busy, 0);
    check({tag, " mem_dest"}, mem[v.d], v.exp_w);
    check({tag, " idle_after"}, start_ready, 1);
  endtask

  // dut2: resp = 0 means never answer.
  task automatic run2(input int resp, output obs_t o);
    int cyc;
    o = '{default: 0};
    start_valid2 = 1'b1;
    @(posedge clk); #1;
    start_valid2 = 1'b0;
    o.terr_start = t_err2;
    cyc = 1;
    while (cyc < 100) begin
      res_valid2 = 1'b0;
      if (!n_en2) o.reads_a++;
      if (!rnw2) begin o.write_cnt++; o.w_data = bus2; o.wr_cyc = cyc; end
      if (res_ready2) begin
        o.ready_cnt++;
        if (o.ready_cnt == resp) res_valid2 = 1'b1;
      end
      if (done2) begin o.done_cyc = cyc; o.terr = t_err2; end
      @(posedge clk); #1;
      if (o.done_cyc != 0) break;
      cyc++;
    end
    res_valid2 = 1'b0;
  endtask

  // ---------------- test ----------------
  vec_t tbl [4];
  vec_t bb1, bb2;
  obs_t o;
  int   pulses;

  initial begin
    tbl[0] = mk(0,  1,  2,  1'b0, 1,  5, 7,  8);
    tbl[1] = mk(1,  7,  3,  1'b1, 1,  3, 5,  6);
    tbl[2] = mk(4,  5,  6,  1'b0, 10, 5, 16, 17);
    tbl[3] = mk(12, 13, 12, 1'b1, 3,  3, 7,  8);
    bb1    = mk(20, 21, 22, 1'b0, 1,  5, 7,  8);
    bb2    = mk(23, 24, 25, 1'b0, 1,  5, 7,  8);
    for (int i = 0; i < 256; i++) mem[i] = pattern(i);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("rst startReady", start_ready, 1);
    check("rst enable_n/rnw", {n_en, rnw}, 2'b11);
    check("rst address", addr, 0);
    check("rst operandA", op_a, 0);
    check("rst operandB", op_b, 0);
    check("rst pulses", {op_valid, res_ready, done, t_err}, 0);
    check("rst bus released", bus, 0);
    check("rst dut2 timeoutError", t_err2, 0);

    // Table-driven commands
    for (int i = 0; i < 4; i++) begin
      run_cmd(tbl[i], 1'b0, tbl[i], o);
      check_cmd($sformatf("vec%0d", i), tbl[i], o);
      $display("vec%0d: srcA=%0d srcB=%0d dest=%0d single=%0d valid@%0d write@%0d done@%0d",
               i, tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].s, o.valid_cyc, o.wr_cyc, o.done_cyc);
    end

    // Back-to-back: second command waits behind the first with startValid held
    run_cmd(bb1, 1'b1, bb2, o);
    check_cmd("b2b first", bb1, o);
    run_cmd(bb2, 1'b0, bb2, o);
    check_cmd("b2b second", bb2, o);
    $display("b2b: second command done@%0d", o.done_cyc);

    // Reset in the middle of RDB_CAP
    src_a = 8'd30; src_b = 8'd31; dest = 8'd32; single = 1'b0; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("midrst in RDB_CAP", {n_en, rnw, addr}, {1'b0, 1'b1, 8'd31});
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst enable_n", n_en, 1);
    check("midrst bus released", bus, 0);
    check("midrst startReady", start_ready, 1);
    check("midrst operandA", op_a, 0);
    pulses = 0;
    repeat (6) begin
      if (op_valid) pulses++;
      @(posedge clk); #1;
    end
    check("midrst operandValid pulses", pulses, 0);
    $display("midrst: bus released, operandValid pulses=%0d", pulses);

    // Timeout with RESULT_TIMEOUT=4, no result ever
    run2(0, o);
    check("tmo ready_cycles", o.ready_cnt, 4);
    check("tmo done_cycle", o.done_cyc, 10);
    check("tmo timeoutError", o.terr, 1);
    check("tmo write_count", o.write_cnt, 0);
    check("tmo enabled_cycles", o.reads_a, 4);
    check("tmo error held", t_err2, 1);
    $display("timeout: done@%0d timeoutError=%0d", o.done_cyc, o.terr);

    // Result on the same cycle the counter reaches the limit: result wins
    run2(4, o);
    check("edge terr cleared on accept", o.terr_start, 0);
    check("edge write_count", o.write_cnt, 1);
    check("edge write_cycle", o.wr_cyc, 10);
    check("edge write_data", o.w_data, 256'hBEEF_0123);
    check("edge done_cycle", o.done_cyc, 11);
    check("edge timeoutError", o.terr, 0);
    $display("late result: write@%0d done@%0d timeoutError=%0d", o.wr_cyc, o.done_cyc, o.terr);

    check("bus monitor dut1", bus_viol, 0);
    check("bus monitor dut2", bus_viol2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
